fib_run_ctrl: RTL and testbench
===============================

# fib_run_ctrl

Wishbone-programmable run controller for the Fibonacci engine. It sequences the engine's enable and clock select through an idle/arm/run/done state machine, counts generated terms by watching the engine's pad value, and detects wrap-around and stall. It raises maskable interrupts and sits beside the existing Wishbone control slave in the user project area, on its own address window.

## Interface
- BASE_ADDRESS, 32'h30000100, base of this block's 256-byte window
- CLOCK_WIDTH, 6, width of the clock-select output
- VAL_WIDTH, 30, width of the observed Fibonacci value
- SETTLE_CYCLES, 4, cycles enable is held low in ARM after clock select is applied (≥1)
- wb_clk_i  in  1  clock
- reset  in  1  synchronous, active-high; clock wb_clk_i
- wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1 each  Wishbone strobe/cycle/write
- wbs_sel_i  in  4  byte selects
- wbs_adr_i  in  32  byte address
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  registered acknowledge
- wbs_dat_o  out  32  registered read data
- fib_val_i  in  VAL_WIDTH  engine value from pads, asynchronous to wb_clk_i
- fib_enable_o  out  1  engine run enable
- fib_clock_sel_o  out  CLOCK_WIDTH  engine clock select
- irq_o  out  3  [0] done, [1] wrap, [2] timeout; pending & enable

## Operation
- Register map (offsets from BASE_ADDRESS):
  - 0x00 CTRL: W bit0 START, bit1 ABORT (pulses, read as 0); RW bits[4:2] IRQ_EN, reset 0.
  - 0x04 TARGET: RW 32-bit term count, reset 0. 0 means run until abort or timeout.
  - 0x08 CLKSEL: RW, reset 1. Writes are ignored unless the state is IDLE or DONE.
  - 0x0C TIMEOUT: RW 32-bit stall limit in cycles, reset 0. 0 disables the timeout.
  - 0x10 STATUS: R [1:0] state (IDLE=0, ARM=1, RUN=2, DONE=3), [4:2] pending. Writing 1 to a bit in [4:2] clears it.
  - 0x14 COUNT: R terms counted since the last ARM.
  - 0x18 LAST: R last captured value, zero-extended.
- Decode: adr[31:8]==BASE_ADDRESS[31:8] selects the window. Other offsets in the window read 0, ignore writes, and are acked.
- Writes take effect only when wbs_sel_i==4'hF. Partial writes are acked but ignored.
- fib_val_i passes through a 2-flop synchronizer to give sync_val. A change is sync_val != prev_val, and prev_val <= sync_val every cycle.
- IDLE: enable 0. START -> ARM.
- ARM: enable 0. Clears COUNT and the stall counter, then counts SETTLE_CYCLES and moves to RUN.
- RUN: enable 1. On each change:
  - COUNT += 1 and LAST <= sync_val.
  - If sync_val < prev_val, set pending[1]; the state stays RUN.
  - If TARGET!=0 and the new COUNT==TARGET, set pending[0] and go to DONE.
- RUN stall: the stall counter increments on every cycle without a change and clears on a change. If TIMEOUT!=0 and the counter reaches TIMEOUT, set pending[2] and go to DONE.
- DONE: enable 0. START -> ARM.
- ABORT from any state -> IDLE. No pending bit is set.
- Simultaneous events:
  - START and ABORT in the same write: ABORT wins.
  - Change and timeout in the same cycle: the change wins and the counter clears.
  - Hardware set and W1C of the same bit in the same cycle: the set wins.
- COUNT saturates at 32'hFFFFFFFF.

## Timing
- Reset values: wbs_ack_o 0, wbs_dat_o 0, fib_enable_o 0, fib_clock_sel_o 1, irq_o 0, state IDLE, all registers as listed above.
- Ack: request seen at edge N gives wbs_ack_o=1 after N for exactly one cycle. Ack is suppressed while it is already high, so back-to-back requests get one idle cycle between acks.
- Read data is valid in the ack cycle and is 0 otherwise.
- Write side effects, including the state change, take effect on the same edge that raises ack.
- START at edge N: state ARM after N, RUN after edge N+SETTLE_CYCLES. fib_enable_o rises with RUN.
- Change latency: a fib_val_i change is reflected in COUNT/LAST 3 edges later (2 synchronizer edges, 1 compare edge).
- irq_o is combinational from the pending and IRQ_EN registers, with no extra latency.
- Reset mid-run: fib_enable_o is 0 after the reset edge and all state is restored.

## Test plan
- Reset, then read 0x10/0x08 -> 0x0 and 0x1. Read offset 0x40 -> 0, acked one cycle after stb.
- IRQ_EN=3'b001, TARGET=5, START, drive values 1,2,3,5,8 with 20-cycle spacing -> enable high 4 cycles after START ack. COUNT=5, LAST=8, state DONE, irq_o=3'b001, enable 0.
- TARGET=0, run, drive 0x3FFFFFFF then 0x00000001 -> pending[1] set. State stays RUN. Write 0x10 with bit3=1 -> pending[1] clears.
- TIMEOUT=10, run, hold fib_val_i constant -> pending[2] set and DONE exactly 10 cycles into RUN.
- In RUN, write CLKSEL=6'h04 -> ignored (reads 1). ABORT -> IDLE with no irq. CLKSEL=6'h04 then accepted and seen on fib_clock_sel_o.
- Assert reset while in RUN with COUNT=3 -> next cycle: enable 0, COUNT 0, state IDLE, ack 0.

Source files
------------

// File: rtl/fib_run_ctrl.sv
// fib_run_ctrl
// Wishbone-programmable run controller for the Fibonacci engine. Sequences
// the engine enable / clock select through IDLE -> ARM -> RUN -> DONE, counts
// generated terms by watching the (asynchronous) pad value, and flags
// wrap-around, target reached and stall timeout as maskable interrupts.
//
// Ports:
//   wb_clk_i, reset        clock, synchronous active-high reset
//   wbs_*                  Wishbone slave (registered ack / read data)
//   fib_val_i              engine value from pads (async, synchronized here)
//   fib_enable_o           engine run enable (high only in RUN)
//   fib_clock_sel_o        engine clock select (CLKSEL register)
//   irq_o                  [0] done, [1] wrap, [2] timeout = pending & IRQ_EN
module fib_run_ctrl #(
  parameter logic [31:0] BASE_ADDRESS  = 32'h30000100,
  parameter int unsigned CLOCK_WIDTH   = 6,
  parameter int unsigned VAL_WIDTH     = 30,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic                   wb_clk_i,
  input  logic                   reset,
  input  logic                   wbs_stb_i,
  input  logic                   wbs_cyc_i,
  input  logic                   wbs_we_i,
  input  logic [3:0]             wbs_sel_i,
  input  logic [31:0]            wbs_adr_i,
  input  logic [31:0]            wbs_dat_i,
  output logic                   wbs_ack_o,
  output logic [31:0]            wbs_dat_o,
  input  logic [VAL_WIDTH-1:0]   fib_val_i,
  output logic                   fib_enable_o,
  output logic [CLOCK_WIDTH-1:0] fib_clock_sel_o,
  output logic [2:0]             irq_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ARM  = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  // Registers
  logic [1:0]             state, state_n;
  logic [2:0]             irq_en;
  logic [31:0]            target;
  logic [CLOCK_WIDTH-1:0] clksel;
  logic [31:0]            timeout;
  logic [2:0]             pending;
  logic [31:0]            count, count_n;
  logic [VAL_WIDTH-1:0]   last, last_n;
  logic [31:0]            stall, stall_n;
  logic [SW-1:0]          settle, settle_n;
  logic [VAL_WIDTH-1:0]   sync1, sync_val, prev_val;

  // Bus decode
  logic       req, wr, rd;
  logic [7:0] off;
  logic       wr_ctrl, wr_target, wr_clksel, wr_timeout, wr_status;
  logic       start_cmd, abort_cmd;
  logic [2:0] hw_set, w1c;
  logic [31:0] rd_data;
  logic       change;
  logic [31:0] count_inc, stall_inc;

  assign off = wbs_adr_i[7:0];
  assign req = wbs_stb_i & wbs_cyc_i & ~wbs_ack_o &
               (wbs_adr_i[31:8] == BASE_ADDRESS[31:8]);
  assign wr  = req & wbs_we_i & (wbs_sel_i == 4'hF);
  assign rd  = req & ~wbs_we_i;

  assign wr_ctrl    = wr & (off == 8'h00);
  assign wr_target  = wr & (off == 8'h04);
  assign wr_clksel  = wr & (off == 8'h08);
  assign wr_timeout = wr & (off == 8'h0C);
  assign wr_status  = wr & (off == 8'h10);

  // ABORT takes priority over START in the same write.
  assign abort_cmd = wr_ctrl & wbs_dat_i[1];
  assign start_cmd = wr_ctrl & wbs_dat_i[0] & ~wbs_dat_i[1];
  assign w1c       = wr_status ? wbs_dat_i[4:2] : 3'b000;

  assign change    = (sync_val != prev_val);
  assign count_inc = (count == '1) ? count : count + 32'd1;
  assign stall_inc = (stall == '1) ? stall : stall + 32'd1;

  always_comb begin
    state_n  = state;
    count_n  = count;
    last_n   = last;
    stall_n  = stall;
    settle_n = settle;
    hw_set   = 3'b000;
    if (abort_cmd) begin
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start_cmd) begin
            state_n  = ST_ARM;
            settle_n = '0;
            count_n  = '0;
            stall_n  = '0;
          end
        end
        ST_ARM: begin
          count_n = '0;
          stall_n = '0;
          if (settle == SETTLE_LAST) state_n = ST_RUN;
          else                       settle_n = settle + 1'b1;
        end
        ST_RUN: begin
          // A change in the same cycle as a timeout wins and clears the stall count.
          if (change) begin
            count_n = count_inc;
            last_n  = sync_val;
            stall_n = '0;
            if (sync_val < prev_val) hw_set[1] = 1'b1;
            if ((target != 32'd0) && (count_inc == target)) begin
              hw_set[0] = 1'b1;
              state_n   = ST_DONE;
            end
          end else begin
            stall_n = stall_inc;
            if ((timeout != 32'd0) && (stall_inc >= timeout)) begin
              hw_set[2] = 1'b1;
              state_n   = ST_DONE;
            end
          end
        end
        default: state_n = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    rd_data = '0;
    case (off)
      8'h00: rd_data = {27'd0, irq_en, 2'b00};
      8'h04: rd_data = target;
      8'h08: rd_data = 32'(clksel);
      8'h0C: rd_data = timeout;
      8'h10: rd_data = {27'd0, pending, state};
      8'h14: rd_data = count;
      8'h18: rd_data = 32'(last);
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_i) begin
    if (reset) begin
      wbs_ack_o <= 1'b0;
      wbs_dat_o <= '0;
      state     <= ST_IDLE;
      irq_en    <= '0;
      target    <= '0;
      clksel    <= CLOCK_WIDTH'(1);
      timeout   <= '0;
      pending   <= '0;
      count     <= '0;
      last      <= '0;
      stall     <= '0;
      settle    <= '0;
      sync1     <= '0;
      sync_val  <= '0;
      prev_val  <= '0;
    end else begin
      wbs_ack_o <= req;
      wbs_dat_o <= rd ? rd_data : '0;
      state     <= state_n;
      count     <= count_n;
      last      <= last_n;
      stall     <= stall_n;
      settle    <= settle_n;
      sync1     <= fib_val_i;
      sync_val  <= sync1;
      prev_val  <= sync_val;
      if (wr_ctrl)    irq_en  <= wbs_dat_i[4:2];
      if (wr_target)  target  <= wbs_dat_i;
      if (wr_timeout) timeout <= wbs_dat_i;
      if (wr_clksel && ((state == ST_IDLE) || (state == ST_DONE)))
        clksel <= wbs_dat_i[CLOCK_WIDTH-1:0];
      // Hardware set is OR-ed in after the clear so it wins.
      pending <= (pending & ~w1c) | hw_set;
    end
  end

  assign fib_enable_o    = (state == ST_RUN);
  assign fib_clock_sel_o = clksel;
  assign irq_o           = pending & irq_en;

endmodule

// File: tb/tb_fib_run_ctrl.sv
// Scoreboard bench for fib_run_ctrl: bus transactions push their expected
// read data into a queue, a monitor pops and compares on every ack. The
// reference model tracks the register map and counts value changes directly
// from the sequence of values the bench drives.
module tb_fib_run_ctrl;
  localparam logic [31:0] BASE   = 32'h30000100;
  localparam logic [31:0] VMASK  = 32'h3FFFFFFF;
  localparam int unsigned SETTLE = 4;
  localparam logic [1:0] M_IDLE = 2'd0, M_ARM = 2'd1, M_RUN = 2'd2, M_DONE = 2'd3;

  logic        wb_clk_i = 1'b0;
  logic        reset = 1'b1;
  logic        wbs_stb_i = 1'b0, wbs_cyc_i = 1'b0, wbs_we_i = 1'b0;
  logic [3:0]  wbs_sel_i = 4'h0;
  logic [31:0] wbs_adr_i = '0, wbs_dat_i = '0;
  logic        wbs_ack_o;
  logic [31:0] wbs_dat_o;
  logic [29:0] fib_val_i = '0;
  logic        fib_enable_o;
  logic [5:0]  fib_clock_sel_o;
  logic [2:0]  irq_o;

  fib_run_ctrl #(.BASE_ADDRESS(BASE), .CLOCK_WIDTH(6), .VAL_WIDTH(30),
                 .SETTLE_CYCLES(SETTLE)) dut (
    .wb_clk_i(wb_clk_i), .reset(reset),
    .wbs_stb_i(wbs_stb_i), .wbs_cyc_i(wbs_cyc_i), .wbs_we_i(wbs_we_i),
    .wbs_sel_i(wbs_sel_i), .wbs_adr_i(wbs_adr_i), .wbs_dat_i(wbs_dat_i),
    .wbs_ack_o(wbs_ack_o), .wbs_dat_o(wbs_dat_o),
    .fib_val_i(fib_val_i), .fib_enable_o(fib_enable_o),
    .fib_clock_sel_o(fib_clock_sel_o), .irq_o(irq_o));

  always #5 wb_clk_i = ~wb_clk_i;

  int tests = 0;
  int fails = 0;

  typedef struct { bit is_read; logic [31:0] exp; string name; } txn_t;
  txn_t sb[$];

  // Reference model
  logic [1:0]  m_state;
  logic [31:0] m_count, m_last, m_target, m_timeout, cur_val;
  logic [2:0]  m_pend, m_irqen;
  logic [5:0]  m_clksel;

  task automatic model_reset();
    m_state = M_IDLE; m_count = 0; m_last = 0; m_target = 0; m_timeout = 0;
    m_pend = 0; m_irqen = 0; m_clksel = 6'd1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every ack consumes one scoreboard entry.
  txn_t mt;
  always @(negedge wb_clk_i) begin
    if (wbs_ack_o === 1'b1) begin
      if (sb.size() == 0) begin
        tests++; fails++;
        $display("FAIL unexpected_ack: got ack with empty scoreboard, expected none");
      end else begin
        mt = sb.pop_front();
        if (mt.is_read) check(mt.name, wbs_dat_o, mt.exp);
        else            check({mt.name, "_wdata"}, wbs_dat_o, 32'd0);
      end
    end
  end

  task automatic wb_xfer(input bit we, input logic [7:0] off, input logic [31:0] dat,
                         input logic [3:0] sel, input logic [31:0] exp, input string name);
    txn_t t;
    int lat;
    t.is_read = !we; t.exp = exp; t.name = name;
    sb.push_back(t);
    @(negedge wb_clk_i);
    if (wbs_ack_o) @(negedge wb_clk_i);
    wbs_adr_i = BASE | {24'd0, off};
    wbs_dat_i = dat; wbs_sel_i = sel; wbs_we_i = we;
    wbs_stb_i = 1'b1; wbs_cyc_i = 1'b1;
    lat = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge wb_clk_i); #1;
      lat++;
      if (wbs_ack_o) break;
    end
    wbs_stb_i = 1'b0; wbs_cyc_i = 1'b0; wbs_we_i = 1'b0;
    if (!wbs_ack_o) begin
      tests++; fails++;
      $display("FAIL %s_ack_timeout: got no ack, expected ack", name);
      void'(sb.pop_back());
    end else begin
      check({name, "_ack_latency"}, lat, 1);
    end
  endtask

  task automatic reg_read(input logic [7:0] off, input logic [31:0] exp, input string name);
    wb_xfer(1'b0, off, 32'd0, 4'hF, exp, name);
  endtask

  // Write plus register-map level model update.
  task automatic reg_write_sel(input logic [7:0] off, input logic [31:0] dat, input logic [3:0] sel);
    wb_xfer(1'b1, off, dat, sel, 32'd0, $sformatf("wr%02h", off));
    if (sel == 4'hF) begin
      case (off)
        8'h00: begin
          m_irqen = dat[4:2];
          if (dat[1]) m_state = M_IDLE;
          else if (dat[0] && (m_state == M_IDLE || m_state == M_DONE)) begin
            m_state = M_ARM; m_count = 0;
          end
        end
        8'h04: m_target = dat;
        8'h08: if (m_state == M_IDLE || m_state == M_DONE) m_clksel = dat[5:0];
        8'h0C: m_timeout = dat;
        8'h10: m_pend = m_pend & ~dat[4:2];
        default: ;
      endcase
    end
  endtask

  task automatic reg_write(input logic [7:0] off, input logic [31:0] dat);
    reg_write_sel(off, dat, 4'hF);
  endtask

  task automatic ctrl(input bit start, input bit abort);
    reg_write(8'h00, {27'd0, m_irqen, abort, start});
  endtask

  // Called right after the START ack; checks enable rises SETTLE edges later.
  task automatic wait_run();
    int n = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge wb_clk_i); #1;
      n++;
      if (fib_enable_o) break;
    end
    check("run_latency", n, SETTLE);
    m_state = M_RUN;
  endtask

  task automatic drive_val(input logic [31:0] v, input int spacing);
    @(negedge wb_clk_i);
    fib_val_i = v[29:0];
    if (m_state == M_RUN && v != cur_val) begin
      if (v < cur_val) m_pend[1] = 1'b1;
      if (m_count != 32'hFFFFFFFF) m_count++;
      m_last = v;
      if (m_target != 0 && m_count == m_target) begin
        m_pend[0] = 1'b1; m_state = M_DONE;
      end
    end
    cur_val = v;
    repeat (spacing) @(posedge wb_clk_i);
  endtask

  task automatic settle_pipe();
    repeat (5) @(posedge wb_clk_i);
    #1;
  endtask

  task automatic check_status(input string name);
    reg_read(8'h10, {27'd0, m_pend, m_state}, {name, "_status"});
    reg_read(8'h14, m_count, {name, "_count"});
    reg_read(8'h18, m_last, {name, "_last"});
    check({name, "_irq"}, irq_o, m_pend & m_irqen);
    check({name, "_enable"}, fib_enable_o, m_state == M_RUN);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [31:0] v;
    cur_val = 0;
    model_reset();
    repeat (3) @(posedge wb_clk_i);
    @(negedge wb_clk_i); reset = 1'b0;
    #1;
    // Reset state
    check("rst_ack", wbs_ack_o, 0);
    check("rst_dat", wbs_dat_o, 0);
    check("rst_enable", fib_enable_o, 0);
    check("rst_clksel_o", fib_clock_sel_o, 1);
    check("rst_irq", irq_o, 0);
    reg_read(8'h10, 32'd0, "rst_status");
    reg_read(8'h08, 32'd1, "rst_clksel");
    reg_read(8'h00, 32'd0, "rst_ctrl");
    reg_read(8'h04, 32'd0, "rst_target");
    reg_read(8'h0C, 32'd0, "rst_timeout");
    reg_read(8'h40, 32'd0, "unmapped_40");
    reg_write(8'h40, 32'hFFFFFFFF);

    // Target run: 5 terms
    m_irqen = 3'b001;
    reg_write(8'h04, 32'd5);
    ctrl(1'b1, 1'b0);
    wait_run();
    drive_val(1, 20); drive_val(2, 20); drive_val(3, 20);
    drive_val(5, 20); drive_val(8, 20);
    settle_pipe();
    check("tgt_last_exp", m_last, 8);
    check_status("target5");

    // Wrap detection with TARGET=0
    reg_write(8'h04, 32'd0);
    ctrl(1'b1, 1'b0);
    wait_run();
    drive_val(VMASK, 10);
    drive_val(1, 10);
    settle_pipe();
    check_status("wrap");
    reg_write(8'h10, 32'h8);
    reg_read(8'h10, {27'd0, m_pend, m_state}, "wrap_w1c");

    // Timeout: 10 stalled cycles in RUN
    ctrl(1'b0, 1'b1);
    reg_write(8'h10, 32'h1C);
    reg_write(8'h0C, 32'd10);
    m_irqen = 3'b111;
    ctrl(1'b1, 1'b0);
    wait_run();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge wb_clk_i); #1;
      n++;
      if (!fib_enable_o) break;
    end
    check("timeout_cycles", n, 10);
    m_pend[2] = 1'b1; m_state = M_DONE;
    check_status("timeout");

    // CLKSEL locked in RUN, abort, then accepted
    reg_write(8'h10, 32'h1C);
    reg_write(8'h0C, 32'd0);
    ctrl(1'b1, 1'b0);
    wait_run();
    reg_write(8'h08, 32'h04);
    reg_read(8'h08, {26'd0, m_clksel}, "clksel_locked");
    check("clksel_o_locked", fib_clock_sel_o, m_clksel);
    ctrl(1'b0, 1'b1);
    check("abort_irq", irq_o, 0);
    check("abort_enable", fib_enable_o, 0);
    reg_read(8'h10, {27'd0, m_pend, m_state}, "abort_status");
    reg_write(8'h08, 32'h04);
    reg_read(8'h08, {26'd0, m_clksel}, "clksel_open");
    check("clksel_o_open", fib_clock_sel_o, 6'h04);

    // START+ABORT together, and a partial write
    ctrl(1'b1, 1'b1);
    reg_read(8'h10, {27'd0, m_pend, m_state}, "start_abort");
    reg_write_sel(8'h04, 32'h55, 4'h3);
    reg_read(8'h04, m_target, "partial_write");

    // Randomized target runs
    for (int it = 0; it < 10; it++) begin
      m_irqen = 3'($urandom_range(7));
      reg_write(8'h04, 32'($urandom_range(1, 6)));
      ctrl(1'b1, 1'b0);
      wait_run();
      for (int k = 0; k < 100 && m_state == M_RUN; k++) begin
        v = ($urandom_range(3) == 0) ? cur_val : ($urandom & VMASK);
        drive_val(v, $urandom_range(1, 6));
      end
      settle_pipe();
      check_status($sformatf("rnd%0d", it));
      reg_write(8'h10, 32'h1C);
    end

    // Reset in the middle of a run
    reg_write(8'h04, 32'd0);
    ctrl(1'b1, 1'b0);
    wait_run();
    drive_val(cur_val + 1, 4); drive_val(cur_val + 1, 4); drive_val(cur_val + 1, 4);
    settle_pipe();
    reg_read(8'h14, 32'd3, "mid_count");
    @(negedge wb_clk_i); reset = 1'b1;
    @(posedge wb_clk_i); #1;
    check("mrst_enable", fib_enable_o, 0);
    check("mrst_ack", wbs_ack_o, 0);
    check("mrst_irq", irq_o, 0);
    @(negedge wb_clk_i); reset = 1'b0;
    model_reset();
    reg_read(8'h14, 32'd0, "mrst_count");
    reg_read(8'h10, 32'd0, "mrst_status");
    reg_read(8'h08, 32'd1, "mrst_clksel");

    repeat (3) @(posedge wb_clk_i);
    if (sb.size() != 0) begin
      tests++; fails++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
